// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the program counter: clears the PC on start, fetches
// from instruction memory with a timeout, holds the instruction for execute, then advances or jumps.
module pc_sequencer #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             halt_req,
    input  logic [WIDTH-1:0] pc_value,
    output logic             pc_reset,
    output logic             pc_load,
    output logic             pc_inc,
    output logic [WIDTH-1:0] pc_next,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             exec_done,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    output logic             halted,
    output logic             fault
);

    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             fault_q, fault_d;
    logic             timeout_c;

    // Last unacked FETCH cycle before the fault; MAX_WAIT of zero never times out.
    assign timeout_c = (MAX_WAIT != 0) && (wait_q == CNT_W'(MAX_WAIT - 1));

    assign imem_addr = pc_value;
    assign instr     = instr_q;
    assign fault     = fault_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        instr_d     = instr_q;
        fault_d     = fault_q;
        pc_reset    = 1'b0;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_next     = '0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;

        case (state_q)
            S_IDLE: begin
                halted = 1'b1;
                if (run) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                pc_reset = 1'b1;
                wait_d   = '0;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                // An ack wins over the timeout in the same cycle.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end else if (timeout_c) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (exec_done) begin
                    if (jump) begin
                        pc_load = 1'b1;
                        pc_next = jump_addr;
                    end else begin
                        pc_inc = 1'b1;
                    end
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else begin
                        wait_d  = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                halted = 1'b1;
                // A fault locks the sequencer here until reset.
                if (run && !fault_q) begin
                    wait_d  = '0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a PC and memory model around the DUT and a
// scoreboard of expected instructions pushed at each ack and popped when execute sees them.
module tb_pc_sequencer;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned MAX_WAIT = 15;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             run;
    logic             halt_req;
    logic [WIDTH-1:0] pc_value = 16'h1234;
    logic             pc_reset;
    logic             pc_load;
    logic             pc_inc;
    logic [WIDTH-1:0] pc_next;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             exec_done;
    logic             jump;
    logic [WIDTH-1:0] jump_addr;
    logic             halted;
    logic             fault;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [WIDTH-1:0] exp_q[$];

    pc_sequencer #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .halt_req   (halt_req),
        .pc_value   (pc_value),
        .pc_reset   (pc_reset),
        .pc_load    (pc_load),
        .pc_inc     (pc_inc),
        .pc_next    (pc_next),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .exec_done  (exec_done),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External program counter driven by the sequencer's strobes.
    always @(posedge clk) begin
        if (pc_reset)     pc_value <= 16'h0000;
        else if (pc_load) pc_value <= pc_next;
        else if (pc_inc)  pc_value <= pc_value + 16'd1;
    end

    function automatic logic [WIDTH-1:0] mem_word(input logic [WIDTH-1:0] a);
        return a ^ 16'hC35A;
    endfunction

    // Fetch with `delay` unacked cycles; req_cnt counts cycles imem_req was seen, incl. one after the ack.
    task automatic fetch(input logic [WIDTH-1:0] exp_addr, input int delay,
                         output int ack_cyc, output int req_cnt);
        int n = 0;
        ack_cyc = -1;
        req_cnt = 0;
        while (!imem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            $display("FAIL fetch_wait: imem_req=%b after %0d cycles, required 1", imem_req, n);
            errors++;
            return;
        end
        checks++;
        if (imem_addr !== exp_addr) begin
            $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, exp_addr);
            errors++;
        end
        req_cnt = 1;
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            if (imem_req) req_cnt++;
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        exp_q.push_back(mem_word(exp_addr));
        ack_cyc = cyc;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'hBEEF;
        if (imem_req) req_cnt++;
    endtask

    task automatic exec_instr(input logic j, input logic [WIDTH-1:0] ja, input logic h);
        logic [WIDTH-1:0] e;
        checks++;
        if (instr_valid !== 1'b1) begin
            $display("FAIL exec_valid: instr_valid=%b required 1", instr_valid);
            errors++;
        end
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL sb_empty: instr=%h with no expected entry", instr);
            errors++;
        end else begin
            e = exp_q.pop_front();
            if (instr !== e) begin
                $display("FAIL sb_instr: instr=%h required %h", instr, e);
                errors++;
            end
        end
        exec_done = 1'b1;
        jump      = j;
        jump_addr = ja;
        halt_req  = h;
        #1;
        checks++;
        if (pc_load !== j || pc_inc !== !j || pc_reset !== 1'b0) begin
            $display("FAIL exec_strobes: reset/load/inc=%b%b%b required 0%b%b",
                     pc_reset, pc_load, pc_inc, j, !j);
            errors++;
        end
        checks++;
        if (pc_next !== (j ? ja : 16'h0000)) begin
            $display("FAIL exec_pc_next: pc_next=%h required %h", pc_next, j ? ja : 16'h0000);
            errors++;
        end
        @(negedge clk);
        exec_done = 1'b0;
        jump      = 1'b0;
        jump_addr = 16'hDEAD;
        halt_req  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
            pc_reset !== 1'b0 || pc_load !== 1'b0 || pc_inc !== 1'b0) begin
            $display("FAIL reset_ctrl: halted=%b req=%b valid=%b strobes=%b%b%b required 1 0 0 000",
                     halted, imem_req, instr_valid, pc_reset, pc_load, pc_inc);
            errors++;
        end
        checks++;
        if (instr !== 16'h0000 || fault !== 1'b0) begin
            $display("FAIL reset_regs: instr=%h fault=%b required 0000 0", instr, fault);
            errors++;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic start_run();
        @(negedge clk);
        run = 1'b1;
        #1;
        checks++;
        if (pc_reset !== 1'b0 || halted !== 1'b1) begin
            $display("FAIL idle_run: pc_reset=%b halted=%b required 0 1", pc_reset, halted);
            errors++;
        end
        @(negedge clk);
        run = 1'b0;
        checks++;
        if (pc_reset !== 1'b1 || halted !== 1'b0 || imem_req !== 1'b0) begin
            $display("FAIL clear: pc_reset=%b halted=%b req=%b required 1 0 0", pc_reset, halted, imem_req);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (pc_reset !== 1'b0 || imem_req !== 1'b1) begin
            $display("FAIL clear_len: pc_reset=%b req=%b required 0 1", pc_reset, imem_req);
            errors++;
        end
    endtask

    task automatic test_run_sequence();
        int ac, rc, prev;
        prev = -1;
        start_run();
        for (int i = 0; i < 4; i++) begin
            fetch(16'(i), 0, ac, rc);
            if (prev >= 0) begin
                checks++;
                if (ac - prev !== 2) begin
                    $display("FAIL throughput: %0d cycles between fetches required 2", ac - prev);
                    errors++;
                end
            end
            prev = ac;
            exec_instr(1'b0, 16'h0000, 1'b0);
        end
    endtask

    task automatic test_jump();
        int ac, rc;
        fetch(16'h0004, 0, ac, rc);
        exec_instr(1'b0, 16'h0000, 1'b0);
        fetch(16'h0005, 0, ac, rc);
        exec_instr(1'b1, 16'h0100, 1'b0);
        fetch(16'h0100, 0, ac, rc);
        exec_instr(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_wait_states();
        int ac, rc;
        fetch(16'h0101, 3, ac, rc);
        checks++;
        if (rc !== 4 || fault !== 1'b0) begin
            $display("FAIL wait3: req_cycles=%0d fault=%b required 4 0", rc, fault);
            errors++;
        end
        exec_instr(1'b0, 16'h0000, 1'b0);
        fetch(16'h0102, 14, ac, rc);
        checks++;
        if (rc !== 15 || fault !== 1'b0 || instr_valid !== 1'b1) begin
            $display("FAIL wait15: req_cycles=%0d fault=%b valid=%b required 15 0 1", rc, fault, instr_valid);
            errors++;
        end
        exec_instr(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_halt_resume();
        int ac, rc;
        fetch(16'h0103, 0, ac, rc);
        exec_instr(1'b1, 16'h0007, 1'b0);
        fetch(16'h0007, 0, ac, rc);
        exec_instr(1'b0, 16'h0000, 1'b1);
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0) begin
            $display("FAIL halt: halted=%b req=%b required 1 0", halted, imem_req);
            errors++;
        end
        // Execute controls must be ignored while halted.
        exec_done = 1'b1;
        jump      = 1'b1;
        jump_addr = 16'h0F0F;
        #1;
        checks++;
        if (pc_load !== 1'b0 || pc_inc !== 1'b0 || pc_next !== 16'h0000) begin
            $display("FAIL halt_ignore: load=%b inc=%b pc_next=%h required 0 0 0000", pc_load, pc_inc, pc_next);
            errors++;
        end
        @(negedge clk);
        exec_done = 1'b0;
        jump      = 1'b0;
        run       = 1'b1;
        #1;
        checks++;
        if (pc_reset !== 1'b0 || halted !== 1'b1) begin
            $display("FAIL resume_run: pc_reset=%b halted=%b required 0 1", pc_reset, halted);
            errors++;
        end
        @(negedge clk);
        run = 1'b0;
        checks++;
        if (pc_reset !== 1'b0 || halted !== 1'b0) begin
            $display("FAIL resume_fetch: pc_reset=%b halted=%b required 0 0", pc_reset, halted);
            errors++;
        end
        fetch(16'h0008, 0, ac, rc);
        exec_instr(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 15; i++) begin
            checks++;
            if (imem_req !== 1'b1 || fault !== 1'b0) begin
                $display("FAIL timeout_wait: cycle %0d req=%b fault=%b required 1 0", i, imem_req, fault);
                errors++;
            end
            @(negedge clk);
        end
        checks++;
        if (fault !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
            $display("FAIL timeout: fault=%b halted=%b req=%b required 1 1 0", fault, halted, imem_req);
            errors++;
        end
        run      = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        run      = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (fault !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || pc_reset !== 1'b0) begin
            $display("FAIL fault_lock: fault=%b halted=%b req=%b pc_reset=%b required 1 1 0 0",
                     fault, halted, imem_req, pc_reset);
            errors++;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || halted !== 1'b1) begin
            $display("FAIL fault_clear: fault=%b halted=%b required 0 1", fault, halted);
            errors++;
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset_midop();
        int ac, rc;
        start_run();
        fetch(16'h0000, 0, ac, rc);
        exec_instr(1'b0, 16'h0000, 1'b0);
        checks++;
        if (imem_req !== 1'b1 || instr !== mem_word(16'h0000)) begin
            $display("FAIL midfetch_pre: req=%b instr=%h required 1 %h", imem_req, instr, mem_word(16'h0000));
            errors++;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || instr !== 16'h0000 || instr_valid !== 1'b0) begin
            $display("FAIL reset_fetch: halted=%b req=%b instr=%h valid=%b required 1 0 0000 0",
                     halted, imem_req, instr, instr_valid);
            errors++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        start_run();
        fetch(16'h0000, 0, ac, rc);
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL sb_empty: instr=%h with no expected entry", instr);
            errors++;
        end else if (instr !== exp_q.pop_front() || instr_valid !== 1'b1) begin
            $display("FAIL midexec_pre: instr=%h valid=%b required %h 1", instr, instr_valid, mem_word(16'h0000));
            errors++;
        end
        // Reset lands in the exec_done cycle: the PC update must be abandoned.
        exec_done = 1'b1;
        reset_n   = 1'b0;
        #1;
        checks++;
        if (pc_inc !== 1'b0 || pc_load !== 1'b0 || pc_reset !== 1'b0 ||
            instr !== 16'h0000 || instr_valid !== 1'b0 || halted !== 1'b1) begin
            $display("FAIL reset_exec: strobes=%b%b%b instr=%h valid=%b halted=%b required 000 0000 0 1",
                     pc_reset, pc_load, pc_inc, instr, instr_valid, halted);
            errors++;
        end
        @(negedge clk);
        exec_done = 1'b0;
        checks++;
        if (pc_value !== 16'h0000) begin
            $display("FAIL reset_exec_pc: pc_value=%h required 0000", pc_value);
            errors++;
        end
        reset_n = 1'b1;
    endtask

    initial begin
        run        = 1'b0;
        halt_req   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'hBEEF;
        exec_done  = 1'b0;
        jump       = 1'b0;
        jump_addr  = 16'hDEAD;

        test_reset();
        test_run_sequence();
        test_jump();
        test_wait_states();
        test_halt_resume();
        test_timeout();
        test_reset_midop();

        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL sb_leftover: %0d entries remain, required 0", exp_q.size());
            errors++;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
